store_commit_buffer: RTL and testbench

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer.sv | 169 ++++++++++++++++
 tb/tb_store_commit_buffer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds committed stores in a small circular FIFO and
// drains them to dataMemory one at a time, oldest first. A load probe port
// reports whether a load address overlaps any buffered store.
//
// Build option: define STORE_FORWARD_EN to forward data from the youngest
// matching word store whose address matches exactly. Without it, any
// word-granular match only raises loadConflict.
//
// state  | meaning
// IDLE   | no write outstanding; starts one when the buffer is non-empty
// WRITE  | head entry presented on memWrite*, waiting for memWriteDone
module store_commit_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        commitValid,
  input  logic [31:0] commitAddr,
  input  logic [31:0] commitData,
  input  logic [1:0]  commitType,
  output logic        full,
  output logic        empty,
  output logic        memWriteRequest,
  output logic [31:0] memWriteAddr,
  output logic [31:0] memWriteData,
  output logic [1:0]  memWriteType,
  input  logic        memWriteDone,
  input  logic [31:0] loadAddr,
  input  logic        loadQuery,
  output logic        fwdHit,
  output logic [31:0] fwdData,
  output logic        loadConflict
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [1:0]       type_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q;
  logic             req_q;
  logic [31:0]      wr_addr_q, wr_data_q;
  logic [1:0]       wr_type_q;
  logic             push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A push is only legal when not full at the edge, even if the head pops on
  // that same edge; the ROB is told full and must not have committed.
  assign push = commitValid && !full;
  assign pop  = (state_q == ST_WRITE) && memWriteDone;

  assign memWriteRequest = req_q;
  assign memWriteAddr    = wr_addr_q;
  assign memWriteData    = wr_data_q;
  assign memWriteType    = wr_type_q;

  // Next-state pointers and occupancy.
  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      addr_q[tail_q] <= commitAddr;
      data_q[tail_q] <= commitData;
      type_q[tail_q] <= commitType;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Drain FSM with registered write-port outputs; the head entry is latched
  // on entry to WRITE so the request stays stable until memWriteDone.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_type_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            state_q   <= ST_WRITE;
            req_q     <= 1'b1;
            wr_addr_q <= addr_q[head_q];
            wr_data_q <= data_q[head_q];
            wr_type_q <= type_q[head_q];
          end
        end
        ST_WRITE: begin
          if (memWriteDone) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifndef STORE_FORWARD_EN
  // Byte offset is irrelevant when only word-granular conflicts are reported.
  logic unused_load_lo;
  assign unused_load_lo = ^loadAddr[1:0];
`endif

  // Load probe: walk oldest to youngest so the youngest match wins. The head
  // entry stays valid while it is being written.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = '0;
    fwdHit       = 1'b0;
    fwdData      = '0;
    loadConflict = 1'b0;
    if (loadQuery) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (addr_q[idx][31:2] == loadAddr[31:2])) begin
`ifdef STORE_FORWARD_EN
          if ((type_q[idx] == 2'd0) && (addr_q[idx] == loadAddr)) begin
            fwdHit       = 1'b1;
            fwdData      = data_q[idx];
            loadConflict = 1'b0;
          end else begin
            fwdHit       = 1'b0;
            fwdData      = '0;
            loadConflict = 1'b1;
          end
`else
          loadConflict = 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        commitValid;
  logic [31:0] commitAddr;
  logic [31:0] commitData;
  logic [1:0]  commitType;
  logic        full, empty;
  logic        memWriteRequest;
  logic [31:0] memWriteAddr, memWriteData;
  logic [1:0]  memWriteType;
  logic        memWriteDone;
  logic [31:0] loadAddr;
  logic        loadQuery;
  logic        fwdHit;
  logic [31:0] fwdData;
  logic        loadConflict;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  t;
  } ent_t;

  ent_t mq[$];   // model of buffered stores, oldest at index 0
  bit   req_m;   // model: a write request is outstanding

  store_commit_buffer dut (
    .clock(clock), .reset(reset),
    .commitValid(commitValid), .commitAddr(commitAddr),
    .commitData(commitData), .commitType(commitType),
    .full(full), .empty(empty),
    .memWriteRequest(memWriteRequest), .memWriteAddr(memWriteAddr),
    .memWriteData(memWriteData), .memWriteType(memWriteType),
    .memWriteDone(memWriteDone),
    .loadAddr(loadAddr), .loadQuery(loadQuery),
    .fwdHit(fwdHit), .fwdData(fwdData), .loadConflict(loadConflict)
  );

  always #5 clock = ~clock;

  // One clock cycle with the given inputs; updates the reference model from
  // the protocol rules (push when not full, drain one store per request with
  // an idle cycle between writes).
  task automatic tick(input bit cv, input logic [31:0] ca, input logic [31:0] cd,
                      input logic [1:0] ct, input bit done);
    bit was_full;
    bit was_nonempty;
    ent_t e;
    commitValid  = cv;
    commitAddr   = ca;
    commitData   = cd;
    commitType   = ct;
    memWriteDone = done;
    was_full     = (mq.size() == DEPTH);
    was_nonempty = (mq.size() > 0);
    if (req_m && done) begin
      e = mq.pop_front();
      req_m = 1'b0;
    end else if (!req_m && was_nonempty) begin
      req_m = 1'b1;
    end
    if (cv && !was_full) begin
      e.a = ca; e.d = cd; e.t = ct;
      mq.push_back(e);
    end
    @(posedge clock);
    #1;
    commitValid  = 1'b0;
    memWriteDone = 1'b0;
  endtask

  task automatic do_reset(input bit cv, input bit done);
    reset        = 1'b1;
    commitValid  = cv;
    commitAddr   = 32'h0000_0050;
    commitData   = 32'h0000_00EE;
    commitType   = 2'd0;
    memWriteDone = done;
    @(posedge clock);
    #1;
    reset        = 1'b0;
    commitValid  = 1'b0;
    memWriteDone = 1'b0;
    mq.delete();
    req_m = 1'b0;
  endtask

  // Expected {fwdHit, loadConflict, fwdData}: youngest buffered store in the
  // same word decides.
  function automatic logic [33:0] probe_model(input logic q, input logic [31:0] la);
    logic        h = 1'b0;
    logic        c = 1'b0;
    logic [31:0] d = '0;
    if (q) begin
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (mq[k].a[31:2] == la[31:2]) begin
`ifdef STORE_FORWARD_EN
          if (mq[k].t == 2'd0 && mq[k].a == la) begin
            h = 1'b1; d = mq[k].d;
          end else begin
            c = 1'b1;
          end
`else
          c = 1'b1;
`endif
          break;
        end
      end
    end
    return {h, c, d};
  endfunction

  task automatic test_reset();
    loadQuery = 1'b1;
    loadAddr  = 32'h0000_0010;
    do_reset(1'b0, 1'b0);
    #1;
    n_cmp++;
    if ({memWriteRequest, memWriteAddr, memWriteData, memWriteType, empty, full} !==
        {1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: req=%b addr=%h data=%h type=%0d empty=%b full=%b, want 0/0/0/0/1/0",
               memWriteRequest, memWriteAddr, memWriteData, memWriteType, empty, full);
    end
    n_cmp++;
    if ({fwdHit, loadConflict, fwdData} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_probe: hit=%b conf=%b data=%h, want all 0", fwdHit, loadConflict, fwdData);
    end
    loadQuery = 1'b0;
  endtask

  task automatic test_basic();
    do_reset(1'b0, 1'b0);
    tick(1'b1, 32'h10, 32'd5, 2'd0, 1'b0);
    n_cmp++;
    if ({memWriteRequest, empty} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_after_push: req=%b empty=%b, want 0 0", memWriteRequest, empty);
    end
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    n_cmp++;
    if ({memWriteRequest, memWriteAddr, memWriteData, memWriteType} !== {1'b1, 32'h10, 32'd5, 2'd0}) begin
      n_err++;
      $display("FAIL basic_request: req=%b addr=%h data=%h type=%0d, want 1 10 5 0",
               memWriteRequest, memWriteAddr, memWriteData, memWriteType);
    end
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    n_cmp++;
    if ({memWriteRequest, memWriteAddr, memWriteData} !== {1'b1, 32'h10, 32'd5}) begin
      n_err++;
      $display("FAIL basic_hold: req=%b addr=%h data=%h, want 1 10 5", memWriteRequest, memWriteAddr, memWriteData);
    end
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    n_cmp++;
    if ({memWriteRequest, empty} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_done: req=%b empty=%b, want 0 1", memWriteRequest, empty);
    end
  endtask

  task automatic test_full();
    int guard;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'd0, 1'b0);
    n_cmp++;
    if (full !== 1'b1) begin
      n_err++;
      $display("FAIL full_after_four: full=%b, want 1", full);
    end
    tick(1'b1, 32'h200, 32'hBB, 2'd0, 1'b0);
    n_cmp++;
    if ({full, empty} !== 2'b10) begin
      n_err++;
      $display("FAIL full_fifth_ignored: full=%b empty=%b, want 1 0", full, empty);
    end
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (!memWriteRequest && guard < 8) begin
        tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        guard++;
      end
      n_cmp++;
      if ({memWriteRequest, memWriteAddr, memWriteData} !== {1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k)}) begin
        n_err++;
        $display("FAIL full_drain_%0d: req=%b addr=%h data=%h, want 1 %h %h", k,
                 memWriteRequest, memWriteAddr, memWriteData, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
      end
      tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    n_cmp++;
    if ({memWriteRequest, empty} !== 2'b01) begin
      n_err++;
      $display("FAIL full_drained: req=%b empty=%b, want 0 1", memWriteRequest, empty);
    end
  endtask

  task automatic test_full_pop();
    int guard;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h100 + 32'(4 * i), 32'hC0 + 32'(i), 2'd0, 1'b0);
    guard = 0;
    while (!memWriteRequest && guard < 8) begin
      tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      guard++;
    end
    tick(1'b1, 32'h300, 32'hCC, 2'd0, 1'b1);
    n_cmp++;
    if ({full, empty} !== 2'b00) begin
      n_err++;
      $display("FAIL fullpop_count: full=%b empty=%b, want 0 0", full, empty);
    end
    for (int k = 1; k < 4; k++) begin
      guard = 0;
      while (!memWriteRequest && guard < 8) begin
        tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        guard++;
      end
      n_cmp++;
      if ({memWriteRequest, memWriteAddr, memWriteData} !== {1'b1, 32'h100 + 32'(4 * k), 32'hC0 + 32'(k)}) begin
        n_err++;
        $display("FAIL fullpop_drain_%0d: req=%b addr=%h data=%h", k, memWriteRequest, memWriteAddr, memWriteData);
      end
      tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    n_cmp++;
    if ({memWriteRequest, empty} !== 2'b01) begin
      n_err++;
      $display("FAIL fullpop_dropped: req=%b empty=%b, want 0 1", memWriteRequest, empty);
    end
  endtask

  task automatic test_probe();
    do_reset(1'b0, 1'b0);
`ifdef STORE_FORWARD_EN
    tick(1'b1, 32'h20, 32'd7, 2'd0, 1'b0);
    tick(1'b1, 32'h20, 32'd9, 2'd0, 1'b0);
    loadQuery = 1'b1;
    loadAddr  = 32'h20;
    #1;
    n_cmp++;
    if ({fwdHit, loadConflict, fwdData} !== {1'b1, 1'b0, 32'd9}) begin
      n_err++;
      $display("FAIL fwd_youngest: hit=%b conf=%b data=%h, want 1 0 9", fwdHit, loadConflict, fwdData);
    end
    tick(1'b1, 32'h21, 32'h55, 2'd2, 1'b0);
    #1;
    n_cmp++;
    if ({fwdHit, loadConflict, fwdData} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL fwd_byte_conflict: hit=%b conf=%b data=%h, want 0 1 0", fwdHit, loadConflict, fwdData);
    end
`else
    tick(1'b1, 32'h22, 32'h33, 2'd1, 1'b0);
    loadQuery = 1'b1;
    loadAddr  = 32'h20;
    #1;
    n_cmp++;
    if ({fwdHit, loadConflict, fwdData} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL probe_word_conflict: hit=%b conf=%b data=%h, want 0 1 0", fwdHit, loadConflict, fwdData);
    end
    loadAddr = 32'h40;
    #1;
    n_cmp++;
    if ({fwdHit, loadConflict, fwdData} !== 34'h0) begin
      n_err++;
      $display("FAIL probe_no_match: hit=%b conf=%b data=%h, want all 0", fwdHit, loadConflict, fwdData);
    end
    loadAddr = 32'h20;
`endif
    loadQuery = 1'b0;
    #1;
    n_cmp++;
    if ({fwdHit, loadConflict, fwdData} !== 34'h0) begin
      n_err++;
      $display("FAIL probe_query_low: hit=%b conf=%b data=%h, want all 0", fwdHit, loadConflict, fwdData);
    end
  endtask

  task automatic test_reset_abort();
    int guard;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h400 + 32'(4 * i), 32'h11 + 32'(i), 2'd0, 1'b0);
    guard = 0;
    while (!memWriteRequest && guard < 8) begin
      tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      guard++;
    end
    do_reset(1'b1, 1'b1);
    n_cmp++;
    if ({memWriteRequest, empty, full, memWriteAddr} !== {1'b1 == 1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL abort_state: req=%b empty=%b full=%b addr=%h, want 0 1 0 0",
               memWriteRequest, empty, full, memWriteAddr);
    end
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    n_cmp++;
    if ({memWriteRequest, empty} !== 2'b01) begin
      n_err++;
      $display("FAIL abort_late_done: req=%b empty=%b, want 0 1", memWriteRequest, empty);
    end
    tick(1'b1, 32'h500, 32'h77, 2'd2, 1'b0);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    n_cmp++;
    if ({memWriteRequest, memWriteAddr, memWriteData, memWriteType} !== {1'b1, 32'h500, 32'h77, 2'd2}) begin
      n_err++;
      $display("FAIL abort_next_write: req=%b addr=%h data=%h type=%0d, want 1 500 77 2",
               memWriteRequest, memWriteAddr, memWriteData, memWriteType);
    end
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [33:0] exp_probe;
    ent_t        h;
    do_reset(1'b0, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        tick(1'($urandom_range(0, 1)), {26'h0, 6'($urandom)}, $urandom,
             2'($urandom_range(0, 2)), $urandom_range(0, 9) < 4);
      end
      loadQuery = ($urandom_range(0, 3) != 0);
      loadAddr  = {26'h0, 6'($urandom)};
      #1;
      n_cmp++;
      if ({memWriteRequest, full, empty} !== {req_m, mq.size() == DEPTH, mq.size() == 0}) begin
        n_err++;
        $display("FAIL rand_ctrl cyc %0d: req=%b full=%b empty=%b, want %b %b %b", cyc,
                 memWriteRequest, full, empty, req_m, mq.size() == DEPTH, mq.size() == 0);
      end
      if (req_m && mq.size() > 0) begin
        h = mq[0];
        n_cmp++;
        if ({memWriteAddr, memWriteData, memWriteType} !== {h.a, h.d, h.t}) begin
          n_err++;
          $display("FAIL rand_write cyc %0d: addr=%h data=%h type=%0d, want %h %h %0d", cyc,
                   memWriteAddr, memWriteData, memWriteType, h.a, h.d, h.t);
        end
      end
      exp_probe = probe_model(loadQuery, loadAddr);
      n_cmp++;
      if ({fwdHit, loadConflict, fwdData} !== exp_probe) begin
        n_err++;
        $display("FAIL rand_probe cyc %0d addr %h: hit=%b conf=%b data=%h, want %b %b %h", cyc, loadAddr,
                 fwdHit, loadConflict, fwdData, exp_probe[33], exp_probe[32], exp_probe[31:0]);
      end
    end
    loadQuery = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    commitValid  = 1'b0;
    commitAddr   = '0;
    commitData   = '0;
    commitType   = '0;
    memWriteDone = 1'b0;
    loadAddr     = '0;
    loadQuery    = 1'b0;
    req_m        = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_full_pop();
    test_probe();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
